// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the fetch-stage PC controller:
//                FSM state encoding, default reset/trap vectors, drain counter
//                width and a word-alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Fetch controller operating modes
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    // Default vectors: first fetch after reset, misaligned-target trap entry
    localparam logic [31:0] C_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] C_TRAP_PC_DEFAULT  = 32'h0000_0100;

    // Width of the drain bubble counter (supports 1..15 drain cycles)
    localparam int C_DRAIN_CNT_W = 4;

    // Force a byte address onto a 32-bit word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Next-PC selection and debug halt sequencing for the fetch
//                stage. Redirects beat stalls, stalls beat sequential fetch.
//                A halt request holds the PC, injects DRAIN_CYCLES bubbles and
//                parks in HALTED until resume.
//                Optional build macro FETCH_MISALIGN_TRAP_EN: a redirect to a
//                non word-aligned target vectors to TRAP_PC and raises a
//                one-cycle registered trap pulse. Without it the target is
//                silently word-aligned and the trap port does not exist.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = C_RESET_PC_DEFAULT,
    parameter logic [31:0] TRAP_PC      = C_TRAP_PC_DEFAULT,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        halt_req,
    input  logic        resume_req,
    output logic [31:0] PCF_new,
    output logic        en,
    output logic        FlushD,
    output logic        halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        trap
`endif
);

    // Counter is loaded with N-1 so that the cycle reading zero is the last bubble
    localparam logic [C_DRAIN_CNT_W-1:0] c_drain_load = C_DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    fetch_state_t               r_state;
    fetch_state_t               w_state_next;
    logic [C_DRAIN_CNT_W-1:0]   r_drain_cnt;
    logic [C_DRAIN_CNT_W-1:0]   w_drain_cnt_next;
    logic [31:0]                w_redirect_pc;
    logic                       w_redirect_taken;

    // The fetch PC register is never disabled; holding is done by feeding PCF back
    assign en = 1'b1;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_trap;

    assign w_misaligned  = |PCTargetE[1:0];
    assign w_redirect_pc = w_misaligned ? TRAP_PC : word_align(PCTargetE);
    assign trap          = r_trap;

    // Trap pulse: registered for exactly the cycle after a misaligned redirect
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_redirect_taken & w_misaligned;
        end
    end
`else
    logic w_unused;

    // Low target bits are dropped; keep otherwise-idle signals referenced
    assign w_redirect_pc = word_align(PCTargetE);
    assign w_unused      = ^{PCTargetE[1:0], TRAP_PC, w_redirect_taken};
`endif

    // State and drain counter registers; reset returns to BOOT with nothing pending
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_BOOT;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    // Next-state, next-PC and flush selection (zero-cycle response to inputs)
    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_redirect_taken = 1'b0;
        PCF_new          = PCF;
        FlushD           = 1'b0;
        halted           = 1'b0;

        case (r_state)
            ST_BOOT: begin
                PCF_new      = RESET_PC;
                FlushD       = 1'b1;
                w_state_next = ST_RUN;
            end

            ST_RUN: begin
                if (PCSrcE) begin
                    // Redirect wins over both stall and halt for this cycle
                    PCF_new          = w_redirect_pc;
                    FlushD           = 1'b1;
                    w_redirect_taken = 1'b1;
                end else if (halt_req || StallF) begin
                    PCF_new = PCF;
                end else begin
                    PCF_new = PCPlus4F;
                end

                if (halt_req) begin
                    w_state_next     = ST_DRAIN;
                    w_drain_cnt_next = c_drain_load;
                end
            end

            ST_DRAIN: begin
                FlushD = 1'b1;
                // A late-resolving branch still lands, but does not extend the drain
                if (PCSrcE) begin
                    PCF_new          = w_redirect_pc;
                    w_redirect_taken = 1'b1;
                end

                if (r_drain_cnt == '0) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - 1'b1;
                end
            end

            ST_HALTED: begin
                halted = 1'b1;
                FlushD = 1'b1;
                if (resume_req) begin
                    w_state_next = ST_RUN;
                end
            end

            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl. The bench plays the fetch
//                stage (PCF follows PCF_new every cycle) and keeps a mode/
//                bubble-count reference model of the controller behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] P_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] P_TRAP_PC  = 32'h0000_0100;
    localparam int          P_DRAIN    = 4;

    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PCF = '0;
    logic [31:0] PCPlus4F = 32'd4;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        halt_req = 1'b0;
    logic        resume_req = 1'b0;
    logic [31:0] PCF_new;
    logic        en;
    logic        FlushD;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current/next mode, remaining bubbles, trap flag
    int          m_mode = M_BOOT;
    int          n_mode = M_BOOT;
    int          m_left = 0;
    int          n_left = 0;
    bit          m_trap = 1'b0;
    bit          n_trap = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] exp_pcnew = '0;
    bit          exp_flush = 1'b0;
    bit          exp_halted = 1'b0;

    fetch_ctrl #(
        .RESET_PC     (P_RESET_PC),
        .TRAP_PC      (P_TRAP_PC),
        .DRAIN_CYCLES (P_DRAIN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .StallF     (StallF),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .halt_req   (halt_req),
        .resume_req (resume_req),
        .PCF_new    (PCF_new),
        .en         (en),
        .FlushD     (FlushD),
        .halted     (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .trap       (trap)
`endif
    );

    always #5 clk = ~clk;

    // Advance one cycle: commit the model, drive new inputs, compute expectations.
    // Returns 3 time units after the edge, well clear of either clock edge.
    task automatic apply(input bit rst_n, input bit stall, input bit src,
                         input logic [31:0] tgt, input bit hreq, input bit rreq);
        logic [31:0] redir;
        bit          mis;
        @(posedge clk);
        m_mode = n_mode;
        m_left = n_left;
        m_trap = n_trap;
        pc     = exp_pcnew;
        #1;
        reset      = rst_n;
        StallF     = stall;
        PCSrcE     = src;
        PCTargetE  = tgt;
        halt_req   = hreq;
        resume_req = rreq;
        PCF        = pc;
        PCPlus4F   = pc + 32'd4;

        mis = (tgt % 4) != 0;
`ifdef FETCH_MISALIGN_TRAP_EN
        redir = mis ? P_TRAP_PC : tgt - (tgt % 4);
`else
        redir = tgt - (tgt % 4);
`endif
        exp_pcnew  = pc;
        exp_flush  = 1'b0;
        exp_halted = 1'b0;
        n_mode     = m_mode;
        n_left     = m_left;
        n_trap     = 1'b0;
        case (m_mode)
            M_BOOT: begin
                exp_pcnew = P_RESET_PC;
                exp_flush = 1'b1;
                n_mode    = M_RUN;
            end
            M_RUN: begin
                if (src) begin
                    exp_pcnew = redir;
                    exp_flush = 1'b1;
                    n_trap    = mis;
                end else if (!hreq && !stall) begin
                    exp_pcnew = pc + 32'd4;
                end
                if (hreq) begin
                    n_mode = M_DRAIN;
                    n_left = P_DRAIN;
                end
            end
            M_DRAIN: begin
                exp_flush = 1'b1;
                if (src) begin
                    exp_pcnew = redir;
                    n_trap    = mis;
                end
                n_left = m_left - 1;
                if (n_left == 0) n_mode = M_HALT;
            end
            default: begin
                exp_halted = 1'b1;
                exp_flush  = 1'b1;
                if (rreq) n_mode = M_RUN;
            end
        endcase
        if (!rst_n) begin
            n_mode = M_BOOT;
            n_left = 0;
            n_trap = 1'b0;
        end
        #2;
    endtask

    task automatic test_reset();
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (PCF_new !== P_RESET_PC || FlushD !== 1'b1 || halted !== 1'b0 || en !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold pc=%h flush=%b halted=%b en=%b required pc=%h flush=1 halted=0 en=1",
                     PCF_new, FlushD, halted, en, P_RESET_PC);
        end
        apply(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (PCF_new !== 32'h0 || FlushD !== 1'b1) begin
            n_err++;
            $display("FAIL boot_cycle pc=%h flush=%b required pc=0 flush=1", PCF_new, FlushD);
        end
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 0, 0, 0);
            n_vec++;
            if (PCF_new !== 32'(4 * (k + 1)) || FlushD !== 1'b0) begin
                n_err++;
                $display("FAIL seq_%0d pc=%h flush=%b required pc=%h flush=0",
                         k, PCF_new, FlushD, 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_stall();
        apply(1, 0, 0, 0, 0, 0);      // PCF=0x0C -> 0x10
        for (int k = 0; k < 2; k++) begin
            apply(1, 1, 0, 0, 0, 0);
            n_vec++;
            if (PCF_new !== 32'h10 || FlushD !== 1'b0) begin
                n_err++;
                $display("FAIL stall_%0d pc=%h flush=%b required pc=00000010 flush=0", k, PCF_new, FlushD);
            end
        end
        apply(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (PCF_new !== 32'h14) begin
            n_err++;
            $display("FAIL stall_release pc=%h required 00000014", PCF_new);
        end
    endtask

    task automatic test_redirect_stall();
        apply(1, 1, 1, 32'h80, 0, 0);
        n_vec++;
        if (PCF_new !== 32'h80 || FlushD !== 1'b1) begin
            n_err++;
            $display("FAIL redirect_over_stall pc=%h flush=%b required pc=00000080 flush=1", PCF_new, FlushD);
        end
    endtask

    task automatic test_halt();
        apply(1, 0, 1, 32'h20, 0, 0);
        apply(1, 0, 0, 0, 1, 0);
        n_vec++;
        if (PCF_new !== 32'h20 || FlushD !== 1'b0 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt_entry pc=%h flush=%b halted=%b required pc=00000020 flush=0 halted=0",
                     PCF_new, FlushD, halted);
        end
        for (int k = 0; k < P_DRAIN; k++) begin
            apply(1, 0, 0, 0, 0, 0);
            n_vec++;
            if (PCF_new !== 32'h20 || FlushD !== 1'b1 || halted !== 1'b0) begin
                n_err++;
                $display("FAIL drain_%0d pc=%h flush=%b halted=%b required pc=00000020 flush=1 halted=0",
                         k, PCF_new, FlushD, halted);
            end
        end
        apply(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (halted !== 1'b1 || FlushD !== 1'b1 || PCF_new !== 32'h20) begin
            n_err++;
            $display("FAIL halted_state halted=%b flush=%b pc=%h required halted=1 flush=1 pc=00000020",
                     halted, FlushD, PCF_new);
        end
        apply(1, 0, 0, 0, 1, 1);      // both requests high in HALTED: resume
        n_vec++;
        if (halted !== 1'b1 || PCF_new !== 32'h20) begin
            n_err++;
            $display("FAIL resume_cycle halted=%b pc=%h required halted=1 pc=00000020", halted, PCF_new);
        end
        apply(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (PCF_new !== 32'h24 || halted !== 1'b0 || FlushD !== 1'b0) begin
            n_err++;
            $display("FAIL after_resume pc=%h halted=%b flush=%b required pc=00000024 halted=0 flush=0",
                     PCF_new, halted, FlushD);
        end
    endtask

    task automatic test_misalign();
        apply(1, 0, 1, 32'h42, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        n_vec++;
        if (PCF_new !== 32'h100 || FlushD !== 1'b1 || trap !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_vector pc=%h flush=%b trap=%b required pc=00000100 flush=1 trap=0",
                     PCF_new, FlushD, trap);
        end
        apply(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (trap !== 1'b1 || PCF_new !== 32'h104) begin
            n_err++;
            $display("FAIL trap_pulse trap=%b pc=%h required trap=1 pc=00000104", trap, PCF_new);
        end
        apply(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (trap !== 1'b0) begin
            n_err++;
            $display("FAIL trap_clear trap=%b required 0", trap);
        end
`else
        n_vec++;
        if (PCF_new !== 32'h40 || FlushD !== 1'b1) begin
            n_err++;
            $display("FAIL misalign_align pc=%h flush=%b required pc=00000040 flush=1", PCF_new, FlushD);
        end
        apply(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (PCF_new !== 32'h44) begin
            n_err++;
            $display("FAIL misalign_next pc=%h required 00000044", PCF_new);
        end
`endif
    endtask

    task automatic test_drain_redirect();
        apply(1, 0, 0, 0, 1, 0);
        apply(1, 0, 1, 32'h200, 0, 0);  // first drain cycle takes a redirect
        n_vec++;
        if (PCF_new !== 32'h200 || FlushD !== 1'b1) begin
            n_err++;
            $display("FAIL drain_redirect pc=%h flush=%b required pc=00000200 flush=1", PCF_new, FlushD);
        end
        for (int k = 1; k < P_DRAIN; k++) begin
            apply(1, 0, 0, 0, 0, 0);
            n_vec++;
            if (PCF_new !== 32'h200 || halted !== 1'b0) begin
                n_err++;
                $display("FAIL drain_hold_%0d pc=%h halted=%b required pc=00000200 halted=0",
                         k, PCF_new, halted);
            end
        end
        apply(1, 0, 0, 0, 0, 1);
        n_vec++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL drain_no_restart halted=%b required 1", halted);
        end
        apply(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_drain_reset();
        apply(1, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 1, 32'h300, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (PCF_new !== P_RESET_PC || halted !== 1'b0 || FlushD !== 1'b1) begin
            n_err++;
            $display("FAIL drain_reset pc=%h halted=%b flush=%b required pc=%h halted=0 flush=1",
                     PCF_new, halted, FlushD, P_RESET_PC);
        end
        apply(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (PCF_new !== P_RESET_PC + 32'd4 || FlushD !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_seq pc=%h flush=%b required pc=%h flush=0",
                     PCF_new, FlushD, P_RESET_PC + 32'd4);
        end
    endtask

    task automatic test_random();
        bit          r_n, st, sr, hq, rq;
        logic [31:0] tg;
        for (int k = 0; k < 400; k++) begin
            r_n = ($urandom_range(0, 99) >= 2);
            st  = ($urandom_range(0, 99) < 25);
            sr  = ($urandom_range(0, 99) < 15);
            hq  = ($urandom_range(0, 99) < 6);
            rq  = ($urandom_range(0, 99) < 30);
            tg  = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
            apply(r_n, st, sr, tg, hq, rq);
            n_vec++;
            if (PCF_new !== exp_pcnew || FlushD !== exp_flush || halted !== exp_halted || en !== 1'b1) begin
                n_err++;
                $display("FAIL random_%0d pc=%h flush=%b halted=%b en=%b required pc=%h flush=%b halted=%b en=1",
                         k, PCF_new, FlushD, halted, en, exp_pcnew, exp_flush, exp_halted);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            n_vec++;
            if (trap !== m_trap) begin
                n_err++;
                $display("FAIL random_trap_%0d trap=%b required %b", k, trap, m_trap);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_misalign();
        test_drain_redirect();
        test_drain_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first PC fetched after reset.
REQ-002 The block SHALL have parameter TRAP_PC, default 32'h0000_0100, meaning the misaligned-target trap vector (used only with FETCH_MISALIGN_TRAP_EN).
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 4, range 1..15, meaning the bubble cycles injected before halt completes.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-006 The block SHALL have port PCF, input, 32, the current fetch PC.
REQ-007 The block SHALL have port PCPlus4F, input, 32, the sequential next PC.
REQ-008 The block SHALL have port StallF, input, 1, the fetch stall from the hazard unit.
REQ-009 The block SHALL have port PCSrcE, input, 1, the taken branch/jump resolved in EX.
REQ-010 The block SHALL have port PCTargetE, input, 32, the redirect target.
REQ-011 The block SHALL have port halt_req, input, 1, the debug halt request (level).
REQ-012 The block SHALL have port resume_req, input, 1, the debug resume request (level).
REQ-013 The block SHALL have port PCF_new, output, 32, the next PC to the fetch stage.
REQ-014 The block SHALL have port en, output, 1, the fetch PC load enable; the fetch stage clears its PC to 0 when en=0.
REQ-015 The block SHALL have port FlushD, output, 1, the IF/ID bubble insert.
REQ-016 The block SHALL have port halted, output, 1, high while in HALTED.
REQ-017 The block SHALL have port trap, output, 1, a one-cycle misaligned-target pulse (FETCH_MISALIGN_TRAP_EN only).

Function
REQ-018 The FSM SHALL have states BOOT, RUN, DRAIN and HALTED.
REQ-019 In BOOT the block SHALL drive en=1, PCF_new=RESET_PC and FlushD=1, then go unconditionally to RUN next cycle.
REQ-020 en SHALL be 1 in every state; hold SHALL be done by driving PCF_new=PCF, never by en=0.
REQ-021 In RUN, next-PC priority SHALL be PCSrcE (PCF_new=PCTargetE, FlushD=1), then StallF (PCF_new=PCF, FlushD=0), then sequential (PCF_new=PCPlus4F); the response is combinational, zero-cycle.
REQ-022 A redirect coincident with StallF SHALL take the redirect and ignore the stall.
REQ-023 In RUN with halt_req=1 and PCSrcE=0, the block SHALL hold PC, load the drain counter with DRAIN_CYCLES-1 and enter DRAIN.
REQ-024 In RUN with halt_req=1 and PCSrcE=1, the redirect SHALL be applied that cycle and DRAIN entered the next cycle.
REQ-025 In DRAIN the block SHALL drive FlushD=1 and PCF_new=PCF, and decrement the counter each cycle.
REQ-026 A PCSrcE during DRAIN SHALL load PCTargetE once without restarting the counter.
REQ-027 On the DRAIN cycle with counter=0 the block SHALL enter HALTED.
REQ-028 In HALTED the block SHALL drive halted=1, FlushD=1 and PCF_new=PCF; resume_req=1 SHALL return to RUN next cycle, with PCPlus4F sequencing resuming from the held PC.
REQ-029 halt_req SHALL be sampled only in RUN and resume_req only in HALTED; both high in HALTED SHALL resume.

Reset
REQ-030 While reset=0 at a clock edge the block SHALL enter BOOT, clear the drain counter and trap, and drive halted=0 the following cycle.
REQ-031 Reset asserted mid-DRAIN or in HALTED SHALL abort to BOOT with no pending redirect retained.

Configuration
REQ-032 With macro FETCH_MISALIGN_TRAP_EN defined, a redirect with PCTargetE[1:0]!=0 SHALL drive PCF_new=TRAP_PC and FlushD=1, and register trap=1 for exactly the next cycle.
REQ-033 Without FETCH_MISALIGN_TRAP_EN, the block SHALL drive PCF_new={PCTargetE[31:2],2'b00}, and trap SHALL be absent from the port list.

Structure
REQ-034 Package fetch_pkg SHALL hold the FSM state enum and the RESET_PC/TRAP_PC default constants.
REQ-035 The block SHALL be a single module with no sub-module; the 4-bit drain counter is inline.

Verification
REQ-036 Reset low 2 cycles, then high -> BOOT cycle with PCF_new=0, FlushD=1; then PC sequence 0,4,8.
REQ-037 PCF=0x10 with StallF=1 for 2 cycles -> PCF_new=0x10 both cycles; then 0x14.
REQ-038 StallF=1 and PCSrcE=1 with PCTargetE=0x80 -> PCF_new=0x80, FlushD=1.
REQ-039 halt_req at PCF=0x20 with DRAIN_CYCLES=4 -> 4 FlushD cycles at 0x20, then halted=1; resume_req -> PCF_new=0x24 next cycle.
REQ-040 FETCH_MISALIGN_TRAP_EN with PCTargetE=0x42 -> PCF_new=0x100 and a one-cycle trap pulse; without the macro -> PCF_new=0x40.
REQ-041 Reset low during DRAIN -> BOOT, halted=0, PCF_new=RESET_PC.
